// File: rtl/prog_mem_port_pkg.sv
// Shared sizes and FSM encoding for the program-memory fetch port.
// Optional per-word parity is enabled by defining PMEM_PARITY_EN.
package prog_mem_port_pkg;

    localparam int MEM_DATA_WIDTH = 32;
    localparam int MEM_DEPTH      = 1024;
    localparam int WAIT_CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_VALID = 2'd2
    } state_t;

endpackage

// File: rtl/prog_mem_port_pmem_array.sv
// DEPTH x DATA_WIDTH word array: 1 sync read (registered, read-before-write), 1 sync write.
// PMEM_PARITY_EN adds a reset-cleared even-parity bit per word, checked on every read.
module pmem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     rd_par_err,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [DATA_WIDTH-1:0]    wr_data
);

    // Contents deliberately survive reset so a loaded image outlives a core reset.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= mem[rd_idx];
    end

`ifdef PMEM_PARITY_EN
    logic [DEPTH-1:0] par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par        <= '0;
            rd_par_err <= 1'b0;
        end else begin
            if (we)
                par[wr_idx] <= ^wr_data;
            if (rd_en)
                rd_par_err <= (^mem[rd_idx]) ^ par[rd_idx];
        end
    end
`else
    assign rd_par_err = 1'b0;
`endif

endmodule

// File: rtl/prog_mem_port.sv
// Program memory fetch port: one outstanding fetch, rsp_valid WAIT_STATES+1 edges after accept, held until rsp_ready.
// req_ready only in IDLE or when the held response is being taken; loader writes never stall. Parity: PMEM_PARITY_EN.
module prog_mem_port
    import prog_mem_port_pkg::*;
#(
    parameter int DATA_WIDTH  = MEM_DATA_WIDTH,
    parameter int DEPTH       = MEM_DEPTH,
    parameter int ADDR_WIDTH  = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_WIDTH-1:0]    req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_data,
    output logic                     rsp_err,
    input  logic                     ld_we,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0]    ld_data
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-3:0] DEPTH_LIM = (ADDR_WIDTH-2)'(DEPTH);
    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD =
        WAIT_CNT_WIDTH'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_t                    state;
    logic [WAIT_CNT_WIDTH-1:0] wait_cnt;
    logic                      addr_err;
    logic                      addr_err_q;
    logic                      accept;
    logic [DATA_WIDTH-1:0]     rd_data;
    logic                      rd_par_err;

    assign req_ready = rst_n & ((state == ST_IDLE) | ((state == ST_VALID) & rsp_ready));
    assign accept    = req_valid & req_ready;
    assign addr_err  = (req_addr[1:0] != 2'b00) | (req_addr[ADDR_WIDTH-1:2] >= DEPTH_LIM);

    pmem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_en      (accept & ~addr_err),
        .rd_idx     (req_addr[2 +: IDX_W]),
        .rd_data    (rd_data),
        .rd_par_err (rd_par_err),
        .we         (ld_we),
        .wr_idx     (ld_addr),
        .wr_data    (ld_data)
    );

    // The read register doubles as the response register; it only moves on accept.
    assign rsp_data = addr_err_q ? '0 : rd_data;
    assign rsp_err  = addr_err_q | rd_par_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            rsp_valid  <= 1'b0;
            addr_err_q <= 1'b0;
        end else if (accept) begin
            addr_err_q <= addr_err;
            if (WAIT_STATES == 0) begin
                state     <= ST_VALID;
                rsp_valid <= 1'b1;
            end else begin
                state     <= ST_WAIT;
                wait_cnt  <= WAIT_LOAD;
                rsp_valid <= 1'b0;
            end
        end else begin
            case (state)
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        state     <= ST_VALID;
                        rsp_valid <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_VALID: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_mem_port.sv
// Bench for prog_mem_port: instance a has WAIT_STATES=0, instance b has WAIT_STATES=3; loader port shared.
module tb_prog_mem_port;

    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int AW    = 32;
    localparam int IW    = $clog2(DEPTH);

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic          ld_we = 1'b0;
    logic [IW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;

    logic          a_req_valid = 1'b0, a_rsp_ready = 1'b0;
    logic [AW-1:0] a_req_addr = '0;
    logic          a_req_ready, a_rsp_valid, a_rsp_err;
    logic [DW-1:0] a_rsp_data;

    logic          b_req_valid = 1'b0, b_rsp_ready = 1'b0;
    logic [AW-1:0] b_req_addr = '0;
    logic          b_req_ready, b_rsp_valid, b_rsp_err;
    logic [DW-1:0] b_rsp_data;

    exp_t sb_a[$];
    exp_t sb_b[$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    prog_mem_port #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .WAIT_STATES(0)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data), .rsp_err(a_rsp_err),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    prog_mem_port #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .WAIT_STATES(3)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data), .rsp_err(b_rsp_err),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    task automatic load(input logic [IW-1:0] idx, input logic [DW-1:0] d);
        @(negedge clk);
        ld_we = 1'b1; ld_addr = idx; ld_data = d;
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    // Drive one request on instance a (which=0) or b (which=1) until accepted.
    task automatic issue(input bit which, input logic [AW-1:0] addr);
        int n;
        n = 0;
        @(negedge clk);
        if (which) begin b_req_valid = 1'b1; b_req_addr = addr; end
        else       begin a_req_valid = 1'b1; a_req_addr = addr; end
        #1;
        while (!(which ? b_req_ready : a_req_ready) && n < 40) begin
            @(negedge clk); #1; n++;
        end
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input bit which, output bit seen, output logic [DW-1:0] d, output logic e);
        seen = 1'b0; d = '0; e = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (which ? b_rsp_valid : a_rsp_valid) begin
                seen = 1'b1;
                d = which ? b_rsp_data : a_rsp_data;
                e = which ? b_rsp_err : a_rsp_err;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; a_req_valid = 1'b1; b_req_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b0 || b_rsp_valid !== 1'b0 || b_req_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs a_valid=%b a_ready=%b b_valid=%b b_ready=%b expected all 0",
                     a_rsp_valid, a_req_ready, b_rsp_valid, b_req_ready);
        end
        checks++;
        if (a_rsp_data !== '0 || a_rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_rsp data=%h err=%b expected 0/0", a_rsp_data, a_rsp_err);
        end
        a_req_valid = 1'b0; b_req_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++;
        if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready a=%b b=%b expected 1", a_req_ready, b_req_ready);
        end
    endtask

    task automatic test_back_to_back;
        logic [AW-1:0] addrs [4];
        exp_t          exps  [4];
        int sent, got, cyc, first_cyc, last_cyc;
        exp_t e;
        addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h0; addrs[3] = 32'h4;
        exps[0] = '{32'h00000013, 1'b0}; exps[1] = '{32'h00100093, 1'b0};
        exps[2] = '{32'h00000013, 1'b0}; exps[3] = '{32'h00100093, 1'b0};
        sent = 0; got = 0; cyc = 0; first_cyc = 0; last_cyc = 0;
        a_rsp_ready = 1'b1;
        while (got < 4 && cyc < 50) begin
            @(negedge clk);
            if (a_rsp_valid) begin
                checks++;
                if (sb_a.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_unexpected_rsp data=%h", a_rsp_data);
                end else begin
                    e = sb_a.pop_front();
                    if (a_rsp_data !== e.data || a_rsp_err !== e.err) begin
                        failures++;
                        $display("FAIL b2b_data idx=%0d got=%h/%b expected=%h/%b", got, a_rsp_data, a_rsp_err, e.data, e.err);
                    end
                end
                if (got == 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
            end
            if (sent < 4) begin a_req_valid = 1'b1; a_req_addr = addrs[sent]; end
            else a_req_valid = 1'b0;
            #1;
            if (a_req_valid && a_req_ready) begin sb_a.push_back(exps[sent]); sent++; end
            cyc++;
        end
        a_req_valid = 1'b0;
        checks++;
        if (got != 4 || last_cyc - first_cyc != 3) begin
            failures++;
            $display("FAIL b2b_throughput responses=%0d span=%0d expected 4 responses over 3 cycles", got, last_cyc - first_cyc);
        end
    endtask

    task automatic test_wait_states;
        int lat;
        exp_t e;
        b_rsp_ready = 1'b0;
        sb_b.push_back('{32'h00100093, 1'b0});
        issue(1'b1, 32'h4);
        lat = 0;
        @(negedge clk);
        while (!b_rsp_valid && lat < 20) begin lat++; @(negedge clk); end
        checks++;
        if (lat != 3) begin
            failures++;
            $display("FAIL wait_latency got=%0d cycles without rsp_valid expected=3", lat);
        end
        e = sb_b.pop_front();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (b_rsp_valid !== 1'b1 || b_rsp_data !== e.data || b_req_ready !== 1'b0) begin
                failures++;
                $display("FAIL wait_hold k=%0d valid=%b data=%h ready=%b expected 1/%h/0", k, b_rsp_valid, b_rsp_data, b_req_ready, e.data);
            end
            @(negedge clk);
        end
        b_rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (b_rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL wait_release valid=%b expected 0", b_rsp_valid);
        end
    endtask

    task automatic test_addr_error;
        logic [AW-1:0] addrs [4];
        exp_t exps [4];
        exp_t e;
        bit seen; logic [DW-1:0] d; logic er;
        addrs[0] = 32'h2;            exps[0] = '{32'h0, 1'b1};
        addrs[1] = 32'(4 * DEPTH);   exps[1] = '{32'h0, 1'b1};
        addrs[2] = 32'h8000_0000;    exps[2] = '{32'h0, 1'b1};
        addrs[3] = 32'h0;            exps[3] = '{32'h00000013, 1'b0};
        a_rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sb_a.push_back(exps[i]);
            issue(1'b0, addrs[i]);
            wait_rsp(1'b0, seen, d, er);
            e = sb_a.pop_front();
            checks++;
            if (!seen || d !== e.data || er !== e.err) begin
                failures++;
                $display("FAIL addr_err addr=%h seen=%b got=%h/%b expected=%h/%b", addrs[i], seen, d, er, e.data, e.err);
            end
        end
    endtask

    task automatic test_same_edge;
        exp_t e;
        bit seen; logic [DW-1:0] d; logic er;
        a_rsp_ready = 1'b1;
        @(negedge clk);
        ld_we = 1'b1; ld_addr = IW'(1); ld_data = 32'hDEADBEEF;
        a_req_valid = 1'b1; a_req_addr = 32'h4;
        sb_a.push_back('{32'h00100093, 1'b0});
        @(posedge clk);
        #1;
        ld_we = 1'b0; a_req_valid = 1'b0;
        wait_rsp(1'b0, seen, d, er);
        e = sb_a.pop_front();
        checks++;
        if (!seen || d !== e.data || er !== e.err) begin
            failures++;
            $display("FAIL same_edge_old seen=%b got=%h/%b expected=%h/%b", seen, d, er, e.data, e.err);
        end
        sb_a.push_back('{32'hDEADBEEF, 1'b0});
        issue(1'b0, 32'h4);
        wait_rsp(1'b0, seen, d, er);
        e = sb_a.pop_front();
        checks++;
        if (!seen || d !== e.data || er !== e.err) begin
            failures++;
            $display("FAIL same_edge_new seen=%b got=%h/%b expected=%h/%b", seen, d, er, e.data, e.err);
        end
        // A write landing while b is still waiting must not alter its captured word.
        b_rsp_ready = 1'b1;
        sb_b.push_back('{32'h00000013, 1'b0});
        issue(1'b1, 32'h0);
        load(IW'(0), 32'hCAFEF00D);
        wait_rsp(1'b1, seen, d, er);
        e = sb_b.pop_front();
        checks++;
        if (!seen || d !== e.data || er !== e.err) begin
            failures++;
            $display("FAIL late_write seen=%b got=%h/%b expected=%h/%b", seen, d, er, e.data, e.err);
        end
    endtask

`ifdef PMEM_PARITY_EN
    task automatic test_parity;
        logic [DEPTH-1:0] pv;
        exp_t e;
        bit seen; logic [DW-1:0] d; logic er;
        @(negedge clk);
        pv = dut_a.u_array.par;
        pv[1] = ~pv[1];
        force dut_a.u_array.par = pv;
        sb_a.push_back('{32'hDEADBEEF, 1'b1});
        issue(1'b0, 32'h4);
        wait_rsp(1'b0, seen, d, er);
        release dut_a.u_array.par;
        e = sb_a.pop_front();
        checks++;
        if (!seen || d !== e.data || er !== e.err) begin
            failures++;
            $display("FAIL parity seen=%b got=%h/%b expected=%h/%b", seen, d, er, e.data, e.err);
        end
    endtask
`endif

    task automatic test_reset_mid_wait;
        int spurious;
        b_rsp_ready = 1'b1;
        issue(1'b1, 32'h4);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (b_rsp_valid !== 1'b0) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            failures++;
            $display("FAIL reset_abort rsp_valid high on %0d cycles expected 0", spurious);
        end
        checks++;
        if (b_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_abort_ready got=%b expected 1", b_req_ready);
        end
    endtask

    initial begin
        test_reset();
        load(IW'(0), 32'h00000013);
        load(IW'(1), 32'h00100093);
        test_back_to_back();
        test_wait_states();
        test_addr_error();
        test_same_edge();
`ifdef PMEM_PARITY_EN
        test_parity();
`endif
        test_reset_mid_wait();
        checks++;
        if (sb_a.size() != 0 || sb_b.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain a=%0d b=%0d expected 0", sb_a.size(), sb_b.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
